ca_grid_array: RTL and testbench

// - Parametrised WIDTH x HEIGHT SIMD grid of cell_core processors. All cells share one instruction stream.
// - Each cell gets N/W/self/E/S neighbour states. Edge mode is a parameter: toroidal wrap or fixed fill value.
// - Adds a host write port, a registered read port, a double-buffered video snapshot and an execution step counter.
// - Sits between the sequencer (instruction/PC/SP/enable, divergence feedback) and the display/host interfaces.

---
 rtl/ca_pkg.sv | 49 ++++
 rtl/ca_grid_array_cell_core.sv | 55 +++++
 rtl/ca_grid_array.sv | 188 ++++++++++++++++++
 tb/tb_ca_grid_array.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared constants, opcode set and index helpers for the cellular-automaton grid.
package ca_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 12;
  localparam int SP_W    = 5;
  localparam int STEP_W  = 32;

  // Edge handling modes for neighbours that fall off the grid.
  localparam int BND_TORUS = 0;
  localparam int BND_FIXED = 1;

  // Opcode lives in instruction[15:12]; instruction[11:0] is the immediate.
  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_COPY_N  = 4'h1,
    OP_COPY_W  = 4'h2,
    OP_COPY_E  = 4'h3,
    OP_COPY_S  = 4'h4,
    OP_ADD_IMM = 4'h5,
    OP_XOR_IMM = 4'h6,
    OP_LOAD_PC = 4'h7,
    OP_LOAD_SP = 4'h8,
    OP_LOAD_XY = 4'h9,
    OP_CMP_EQ  = 4'hA
  } opcode_e;

  // Neighbour lookup result: wrapped index plus a flag saying the raw index left the grid.
  typedef struct packed {
    logic        off;
    logic [30:0] idx;
  } nbr_t;

  // Address width for a dimension of n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Wraps idx+delta into [0, size) and reports whether it had to wrap.
  function automatic nbr_t nbr_idx(input int idx, input int delta, input int size);
    nbr_t r;
    int   raw;
    raw   = idx + delta;
    r.off = (raw < 0) || (raw >= size);
    r.idx = 31'(((raw % size) + size) % size);
    return r;
  endfunction

endpackage

// File: rtl/ca_grid_array_cell_core.sv
// One SIMD processing element: decodes the broadcast instruction against its own
// state and its four neighbours, producing the candidate next state, the video word
// and its vote for the sequencer's branch-divergence consensus.
module cell_core
  import ca_pkg::*;
#(
  parameter int X               = 0,
  parameter int Y               = 0,
  parameter int REGISTER_LENGTH = 8
) (
  input  logic [INSTR_W-1:0]         i_instruction,
  input  logic [PC_W-1:0]            i_program_counter,
  input  logic [SP_W-1:0]            i_stack_pointer,
  input  logic [REGISTER_LENGTH-1:0] i_self,
  input  logic [REGISTER_LENGTH-1:0] i_north,
  input  logic [REGISTER_LENGTH-1:0] i_west,
  input  logic [REGISTER_LENGTH-1:0] i_east,
  input  logic [REGISTER_LENGTH-1:0] i_south,
  output logic [REGISTER_LENGTH-1:0] o_next_state,
  output logic [REGISTER_LENGTH-1:0] o_next_video,
  output logic                       o_diverge
);

  localparam int RL = REGISTER_LENGTH;
  localparam logic [RL-1:0] CELL_ID = RL'((Y * 16) + X);

  opcode_e       w_opcode;
  logic [RL-1:0] w_imm;

  assign w_opcode = opcode_e'(i_instruction[15:12]);
  assign w_imm    = RL'(i_instruction[11:0]);

  // The displayed value is the committed state, independent of what is about to execute.
  assign o_next_video = i_self;

  // Instruction decode: unknown opcodes behave as NOP and only CMP_EQ can raise the vote.
  always_comb begin
    o_next_state = i_self;
    o_diverge    = 1'b0;
    case (w_opcode)
      OP_COPY_N:  o_next_state = i_north;
      OP_COPY_W:  o_next_state = i_west;
      OP_COPY_E:  o_next_state = i_east;
      OP_COPY_S:  o_next_state = i_south;
      OP_ADD_IMM: o_next_state = i_self + w_imm;
      OP_XOR_IMM: o_next_state = i_self ^ w_imm;
      OP_LOAD_PC: o_next_state = RL'(i_program_counter);
      OP_LOAD_SP: o_next_state = RL'(i_stack_pointer);
      OP_LOAD_XY: o_next_state = CELL_ID;
      OP_CMP_EQ:  o_diverge    = (i_self == w_imm);
      default:    o_next_state = i_self;
    endcase
  end

endmodule

// File: rtl/ca_grid_array.sv
// WIDTH x HEIGHT grid of cell_core elements sharing one instruction stream, with a
// host write port, a registered read port, a double-buffered video snapshot and a
// count of executed steps.
module ca_grid_array
  import ca_pkg::*;
#(
  parameter int                         WIDTH           = 10,
  parameter int                         HEIGHT          = 8,
  parameter int                         REGISTER_LENGTH = 8,
  parameter int                         BOUNDARY_MODE   = BND_TORUS,
  parameter logic [REGISTER_LENGTH-1:0] BOUNDARY_VALUE  = '0,
  localparam int                        XW              = addr_w(WIDTH),
  localparam int                        YW              = addr_w(HEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INSTR_W-1:0]         instruction,
  input  logic [PC_W-1:0]            next_program_counter,
  input  logic [SP_W-1:0]            next_stack_pointer,
  input  logic                       execution_enable,
  output logic                       diverge_consensus,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [XW-1:0]              wr_x,
  input  logic [YW-1:0]              wr_y,
  input  logic [REGISTER_LENGTH-1:0] wr_data,
  input  logic                       rd_en,
  input  logic [XW-1:0]              rd_x,
  input  logic [YW-1:0]              rd_y,
  output logic                       rd_valid,
  output logic [REGISTER_LENGTH-1:0] rd_state,
  output logic [REGISTER_LENGTH-1:0] rd_video,
  output logic                       rd_oob,
  input  logic                       video_swap,
  input  logic                       step_clear,
  output logic [STEP_W-1:0]          step_count
);

  localparam int RL = REGISTER_LENGTH;
  localparam logic [XW:0] WIDTH_LIM  = (XW + 1)'(WIDTH);
  localparam logic [YW:0] HEIGHT_LIM = (YW + 1)'(HEIGHT);

  // A one-wide or one-high grid would make a cell its own neighbour on both sides.
  if ((WIDTH < 2) || (HEIGHT < 2)) begin : g_bad_size
    $error("ca_grid_array: WIDTH and HEIGHT must both be at least 2");
  end

  logic [RL-1:0]             r_state      [HEIGHT][WIDTH];
  logic [RL-1:0]             r_snap       [HEIGHT][WIDTH];
  logic [RL-1:0]             w_next_state [HEIGHT][WIDTH];
  logic [RL-1:0]             w_next_video [HEIGHT][WIDTH];
  logic [WIDTH*HEIGHT-1:0]   w_diverge;

  logic                      r_rd_valid;
  logic [RL-1:0]             r_rd_state;
  logic [RL-1:0]             r_rd_video;
  logic                      r_rd_oob;
  logic [STEP_W-1:0]         r_step_count;

  logic                      w_wr_hit;
  logic                      w_rd_in;

  // Neighbour wiring is resolved at elaboration: each cell gets constant indices and
  // only the off-grid ones in fixed mode are replaced by the fill value.
  for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
    for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
      localparam nbr_t NBR_N = nbr_idx(gy, -1, HEIGHT);
      localparam nbr_t NBR_S = nbr_idx(gy,  1, HEIGHT);
      localparam nbr_t NBR_W = nbr_idx(gx, -1, WIDTH);
      localparam nbr_t NBR_E = nbr_idx(gx,  1, WIDTH);
      localparam int   NY    = int'(NBR_N.idx);
      localparam int   SY    = int'(NBR_S.idx);
      localparam int   WX    = int'(NBR_W.idx);
      localparam int   EX    = int'(NBR_E.idx);

      logic [RL-1:0] w_north;
      logic [RL-1:0] w_south;
      logic [RL-1:0] w_west;
      logic [RL-1:0] w_east;

      assign w_north = ((BOUNDARY_MODE == BND_FIXED) && NBR_N.off) ? BOUNDARY_VALUE : r_state[NY][gx];
      assign w_south = ((BOUNDARY_MODE == BND_FIXED) && NBR_S.off) ? BOUNDARY_VALUE : r_state[SY][gx];
      assign w_west  = ((BOUNDARY_MODE == BND_FIXED) && NBR_W.off) ? BOUNDARY_VALUE : r_state[gy][WX];
      assign w_east  = ((BOUNDARY_MODE == BND_FIXED) && NBR_E.off) ? BOUNDARY_VALUE : r_state[gy][EX];

      cell_core #(
        .X               (gx),
        .Y               (gy),
        .REGISTER_LENGTH (RL)
      ) u_cell (
        .i_instruction     (instruction),
        .i_program_counter (next_program_counter),
        .i_stack_pointer   (next_stack_pointer),
        .i_self            (r_state[gy][gx]),
        .i_north           (w_north),
        .i_west            (w_west),
        .i_east            (w_east),
        .i_south           (w_south),
        .o_next_state      (w_next_state[gy][gx]),
        .o_next_video      (w_next_video[gy][gx]),
        .o_diverge         (w_diverge[gy*WIDTH + gx])
      );
    end
  end

  assign diverge_consensus = &w_diverge;
  assign wr_ready          = !execution_enable;
  assign w_wr_hit          = wr_valid && wr_ready &&
                             ({1'b0, wr_x} < WIDTH_LIM) && ({1'b0, wr_y} < HEIGHT_LIM);
  assign w_rd_in           = ({1'b0, rd_x} < WIDTH_LIM) && ({1'b0, rd_y} < HEIGHT_LIM);

  // Cell state: a step commits every cell at once and locks out host writes that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          r_state[y][x] <= '0;
        end
      end
    end else if (execution_enable) begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          r_state[y][x] <= w_next_state[y][x];
        end
      end
    end else if (w_wr_hit) begin
      r_state[wr_y][wr_x] <= wr_data;
    end
  end

  // Snapshot buffer: the display only ever sees whole frames captured on video_swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          r_snap[y][x] <= '0;
        end
      end
    end else if (video_swap) begin
      for (int y = 0; y < HEIGHT; y++) begin
        for (int x = 0; x < WIDTH; x++) begin
          r_snap[y][x] <= w_next_video[y][x];
        end
      end
    end
  end

  // Read port: captures pre-edge state so a same-cycle write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_state <= '0;
      r_rd_video <= '0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (w_rd_in) begin
          r_rd_state <= r_state[rd_y][rd_x];
          r_rd_video <= r_snap[rd_y][rd_x];
          r_rd_oob   <= 1'b0;
        end else begin
          r_rd_state <= '0;
          r_rd_video <= '0;
          r_rd_oob   <= 1'b1;
        end
      end
    end
  end

  // Step counter: clear wins over an enabled step in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_count <= '0;
    end else if (step_clear) begin
      r_step_count <= '0;
    end else if (execution_enable) begin
      r_step_count <= r_step_count + 32'd1;
    end
  end

  assign rd_valid   = r_rd_valid;
  assign rd_state   = r_rd_state;
  assign rd_video   = r_rd_video;
  assign rd_oob     = r_rd_oob;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_ca_grid_array.sv
// Bench for ca_grid_array: a torus grid and a fixed-boundary grid run side by side
// from the same host stimulus; a behavioural model predicts every read, and a
// scoreboard queue pairs each issued read with the registered response.
module tb_ca_grid_array;

  localparam int          W    = 10;
  localparam int          H    = 8;
  localparam logic [7:0]  FILL = 8'h3C;

  localparam logic [15:0] I_NOP    = 16'h0000;
  localparam logic [15:0] I_COPY_N = 16'h1000;
  localparam logic [15:0] I_ADD1   = 16'h5001;
  localparam logic [15:0] I_CMP42  = 16'hA042;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instruction;
  logic [11:0] pc;
  logic [4:0]  sp;
  logic        executionEnable;
  logic        wrValid;
  logic [3:0]  wrX;
  logic [2:0]  wrY;
  logic [7:0]  wrData;
  logic        rdEn;
  logic [3:0]  rdX;
  logic [2:0]  rdY;
  logic        videoSwap;
  logic        stepClear;

  logic        tDiverge, fDiverge;
  logic        tWrReady, fWrReady;
  logic        tRdValid, fRdValid;
  logic [7:0]  tRdState, fRdState;
  logic [7:0]  tRdVideo, fRdVideo;
  logic        tRdOob, fRdOob;
  logic [31:0] tStepCount, fStepCount;

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] stT;
    logic [7:0] stF;
    logic [7:0] vidT;
    logic [7:0] vidF;
    logic       oob;
  } sbEntry_t;

  sbEntry_t    sbQueue[$];
  sbEntry_t    monEntry;

  logic [7:0]  mT [H][W];
  logic [7:0]  mF [H][W];
  logic [7:0]  sT [H][W];
  logic [7:0]  sF [H][W];
  int          expSteps;

  int          compared   = 0;
  int          mismatched = 0;
  int          cycleCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  ca_grid_array #(
    .WIDTH(W), .HEIGHT(H), .REGISTER_LENGTH(8), .BOUNDARY_MODE(0), .BOUNDARY_VALUE(8'h00)
  ) u_dutTorus (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .next_program_counter(pc), .next_stack_pointer(sp),
    .execution_enable(executionEnable), .diverge_consensus(tDiverge),
    .wr_valid(wrValid), .wr_ready(tWrReady), .wr_x(wrX), .wr_y(wrY), .wr_data(wrData),
    .rd_en(rdEn), .rd_x(rdX), .rd_y(rdY), .rd_valid(tRdValid),
    .rd_state(tRdState), .rd_video(tRdVideo), .rd_oob(tRdOob),
    .video_swap(videoSwap), .step_clear(stepClear), .step_count(tStepCount)
  );

  ca_grid_array #(
    .WIDTH(W), .HEIGHT(H), .REGISTER_LENGTH(8), .BOUNDARY_MODE(1), .BOUNDARY_VALUE(FILL)
  ) u_dutFixed (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .next_program_counter(pc), .next_stack_pointer(sp),
    .execution_enable(executionEnable), .diverge_consensus(fDiverge),
    .wr_valid(wrValid), .wr_ready(fWrReady), .wr_x(wrX), .wr_y(wrY), .wr_data(wrData),
    .rd_en(rdEn), .rd_x(rdX), .rd_y(rdY), .rd_valid(fRdValid),
    .rd_state(fRdState), .rd_video(fRdVideo), .rd_oob(fRdOob),
    .video_swap(videoSwap), .step_clear(stepClear), .step_count(fStepCount)
  );

  // Single comparison point: counts every check and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    wrValid         = 1'b0;
    rdEn            = 1'b0;
    executionEnable = 1'b0;
    videoSwap       = 1'b0;
    stepClear       = 1'b0;
  endtask

  task automatic resetModel();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        mT[y][x] = 8'h00; mF[y][x] = 8'h00; sT[y][x] = 8'h00; sF[y][x] = 8'h00;
      end
    end
    expSteps = 0;
    sbQueue.delete();
  endtask

  // Behavioural step: torus wraps row 0 to row H-1, fixed mode feeds FILL from above.
  task automatic stepModel(input logic [15:0] instr);
    logic [7:0] nT [H][W];
    logic [7:0] nF [H][W];
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        nT[y][x] = mT[y][x];
        nF[y][x] = mF[y][x];
        if (instr[15:12] == 4'h1) begin
          nT[y][x] = mT[(y + H - 1) % H][x];
          nF[y][x] = (y == 0) ? FILL : mF[y - 1][x];
        end else if (instr[15:12] == 4'h5) begin
          nT[y][x] = mT[y][x] + instr[7:0];
          nF[y][x] = mF[y][x] + instr[7:0];
        end
      end
    end
    mT = nT;
    mF = nF;
    expSteps++;
  endtask

  function automatic logic allEqual(input logic isFixed, input logic [7:0] v);
    logic r;
    r = 1'b1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if ((isFixed ? mF[y][x] : mT[y][x]) != v) r = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic sbEntry_t makeEntry(input int x, input int y, input string tag);
    sbEntry_t e;
    e.due = cycleCount + 1;
    e.tag = tag;
    if ((x < W) && (y < H)) begin
      e.stT = mT[y][x]; e.stF = mF[y][x]; e.vidT = sT[y][x]; e.vidF = sF[y][x]; e.oob = 1'b0;
    end else begin
      e.stT = 8'h00; e.stF = 8'h00; e.vidT = 8'h00; e.vidF = 8'h00; e.oob = 1'b1;
    end
    return e;
  endfunction

  task automatic writeCell(input int x, input int y, input logic [7:0] d);
    @(negedge clk);
    idle();
    wrValid = 1'b1; wrX = 4'(x); wrY = 3'(y); wrData = d;
    if ((x < W) && (y < H)) begin
      mT[y][x] = d; mF[y][x] = d;
    end
  endtask

  task automatic issueRead(input int x, input int y, input string tag);
    @(negedge clk);
    idle();
    rdEn = 1'b1; rdX = 4'(x); rdY = 3'(y);
    sbQueue.push_back(makeEntry(x, y, tag));
  endtask

  task automatic readWrite(input int x, input int y, input logic [7:0] d, input string tag);
    @(negedge clk);
    idle();
    rdEn = 1'b1; rdX = 4'(x); rdY = 3'(y);
    wrValid = 1'b1; wrX = 4'(x); wrY = 3'(y); wrData = d;
    sbQueue.push_back(makeEntry(x, y, tag));
    mT[y][x] = d; mF[y][x] = d;
  endtask

  task automatic stepGrid(input logic [15:0] instr, input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle();
      executionEnable = 1'b1; instruction = instr; stepClear = clr;
      stepModel(instr);
      if (clr) expSteps = 0;
    end
  endtask

  task automatic swapVideo();
    @(negedge clk);
    idle();
    videoSwap = 1'b1;
    sT = mT;
    sF = mF;
  endtask

  task automatic checkSteps(input string tag);
    @(negedge clk);
    idle();
    #1;
    checkOutput({tag, "T"}, tStepCount, 32'(expSteps));
    checkOutput({tag, "F"}, fStepCount, 32'(expSteps));
  endtask

  // Response side of the scoreboard: every rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (tRdValid || fRdValid) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spuriousRdValid", {31'b0, tRdValid | fRdValid}, 32'd0);
      end else begin
        monEntry = sbQueue.pop_front();
        checkOutput({monEntry.tag, "/latency"}, 32'(cycleCount), 32'(monEntry.due));
        checkOutput({monEntry.tag, "/validT"}, {31'b0, tRdValid}, 32'd1);
        checkOutput({monEntry.tag, "/validF"}, {31'b0, fRdValid}, 32'd1);
        checkOutput({monEntry.tag, "/stateT"}, {24'b0, tRdState}, {24'b0, monEntry.stT});
        checkOutput({monEntry.tag, "/stateF"}, {24'b0, fRdState}, {24'b0, monEntry.stF});
        checkOutput({monEntry.tag, "/videoT"}, {24'b0, tRdVideo}, {24'b0, monEntry.vidT});
        checkOutput({monEntry.tag, "/videoF"}, {24'b0, fRdVideo}, {24'b0, monEntry.vidF});
        checkOutput({monEntry.tag, "/oobT"}, {31'b0, tRdOob}, {31'b0, monEntry.oob});
        checkOutput({monEntry.tag, "/oobF"}, {31'b0, fRdOob}, {31'b0, monEntry.oob});
      end
    end
  end

  task automatic applyStimulus();
    // Power-on reset.
    rst_n = 1'b0; instruction = I_NOP; pc = 12'h123; sp = 5'h0A;
    wrX = '0; wrY = '0; wrData = '0; rdX = '0; rdY = '0;
    idle();
    resetModel();
    #1;
    checkOutput("porRdValidT", {31'b0, tRdValid}, 32'd0);
    checkOutput("porRdValidF", {31'b0, fRdValid}, 32'd0);
    checkOutput("porStepsT", tStepCount, 32'd0);
    checkOutput("porStepsF", fStepCount, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Host write/read, out-of-range accesses and same-cycle read/write.
    issueRead(0, 0, "rst00");
    writeCell(3, 2, 8'hA5);
    #1;
    checkOutput("wrReadyIdleT", {31'b0, tWrReady}, 32'd1);
    issueRead(3, 2, "wr32");
    issueRead(W, 0, "oobX10");
    issueRead(15, 7, "oobX15");
    writeCell(10, 3, 8'hEE);
    issueRead(0, 3, "oobWrNoAlias");
    readWrite(4, 4, 8'h5A, "rwSame");
    issueRead(4, 4, "rwAfter");

    // Write stalled by a step, then accepted once the step drops.
    writeCell(1, 1, 8'h77);
    @(negedge clk);
    idle();
    executionEnable = 1'b1; instruction = I_NOP;
    wrValid = 1'b1; wrX = 4'd1; wrY = 3'd1; wrData = 8'h11;
    stepModel(I_NOP);
    #1;
    checkOutput("stallWrReadyT", {31'b0, tWrReady}, 32'd0);
    checkOutput("stallWrReadyF", {31'b0, fWrReady}, 32'd0);
    @(negedge clk);
    executionEnable = 1'b0;
    rdEn = 1'b1; rdX = 4'd1; rdY = 3'd1;
    sbQueue.push_back(makeEntry(1, 1, "stallUnchanged"));
    mT[1][1] = 8'h11; mF[1][1] = 8'h11;
    #1;
    checkOutput("releaseWrReadyT", {31'b0, tWrReady}, 32'd1);
    issueRead(1, 1, "stallAccepted");

    // Boundary: rows hold 0x10+y, one copy-north step.
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) writeCell(x, y, 8'h10 + 8'(y));
    end
    stepGrid(I_COPY_N, 1, 1'b0);
    issueRead(0, 0, "bnd00");
    issueRead(5, 0, "bnd50");
    issueRead(9, 0, "bnd90");
    issueRead(3, 3, "bnd33");
    issueRead(7, 7, "bnd77");

    // Snapshot holds through later steps until the next swap.
    swapVideo();
    stepGrid(I_ADD1, 2, 1'b0);
    issueRead(2, 0, "snapHold20");
    issueRead(9, 7, "snapHold97");
    issueRead(4, 4, "snapHold44");
    swapVideo();
    issueRead(2, 0, "snapNew20");
    issueRead(9, 7, "snapNew97");

    // Step counter: clear, count five, clear wins over enable.
    @(negedge clk);
    idle();
    stepClear = 1'b1;
    expSteps = 0;
    checkSteps("stepsCleared");
    stepGrid(I_NOP, 5, 1'b0);
    checkSteps("stepsFive");
    stepGrid(I_NOP, 1, 1'b1);
    checkSteps("stepsClearPriority");

    // Divergence consensus: all agree, then one cell disagrees.
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) writeCell(x, y, 8'h42);
    end
    @(negedge clk);
    idle();
    instruction = I_CMP42;
    #1;
    checkOutput("consensusAllT", {31'b0, tDiverge}, {31'b0, allEqual(1'b0, 8'h42)});
    checkOutput("consensusAllF", {31'b0, fDiverge}, {31'b0, allEqual(1'b1, 8'h42)});
    writeCell(7, 5, 8'h43);
    @(negedge clk);
    idle();
    #1;
    checkOutput("consensusOneT", {31'b0, tDiverge}, {31'b0, allEqual(1'b0, 8'h42)});
    checkOutput("consensusOneF", {31'b0, fDiverge}, {31'b0, allEqual(1'b1, 8'h42)});

    // Asynchronous reset in the middle of a cycle, with a read outstanding.
    stepGrid(I_ADD1, 3, 1'b0);
    checkSteps("stepsBeforeReset");
    issueRead(2, 3, "preRst23");
    issueRead(12, 0, "preRstOob");
    @(posedge clk);
    #1;
    checkOutput("preRstOobFlag", {31'b0, tRdOob}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstRdValidT", {31'b0, tRdValid}, 32'd0);
    checkOutput("rstRdValidF", {31'b0, fRdValid}, 32'd0);
    checkOutput("rstRdOobT", {31'b0, tRdOob}, 32'd0);
    checkOutput("rstRdStateT", {24'b0, tRdState}, 32'd0);
    checkOutput("rstRdVideoF", {24'b0, fRdVideo}, 32'd0);
    checkOutput("rstStepsT", tStepCount, 32'd0);
    checkOutput("rstStepsF", fStepCount, 32'd0);
    resetModel();
    @(negedge clk);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    issueRead(2, 3, "postRst23");
    issueRead(9, 7, "postRst97");
    issueRead(3, 2, "postRst32");

    @(negedge clk);
    idle();
    for (int i = 0; (i < 6) && (sbQueue.size() != 0); i++) @(negedge clk);
    #1;
    checkOutput("scoreboardDrain", 32'(sbQueue.size()), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
